// File: rtl/flow_export_scheduler.sv
// rtl/flow_export_scheduler.sv - queues forced-export requests and issues them to the exporter one at a time
// Optional: define SCHED_DEDUP_EN to discard repeats of the last accepted or in-flight index.
module flow_export_scheduler #(
  parameter int IDX_W       = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              sched_en,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_index,
  output logic              req_ready,
  output logic              export_now,
  output logic [IDX_W-1:0]  export_this,
  input  logic              flow_exported_ok,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [31:0]       issued_cnt,
  output logic [15:0]       dropped_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WW-1:0]    r_wait, w_wait_nxt;
  logic             w_full, w_empty, w_push, w_drop, w_dup;
  logic             w_load, w_ack, w_timeout, w_export_nxt;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign req_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);

`ifdef SCHED_DEDUP_EN
  logic [IDX_W-1:0] r_last_idx;
  logic             r_last_vld;
  assign w_dup = (r_last_vld && (req_index == r_last_idx)) ||
                 ((r_state == S_ISSUE) && (req_index == export_this));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_last_idx <= '0;
      r_last_vld <= 1'b0;
    end else if (flush) begin
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last_idx <= req_index;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // A flush swallows a concurrent request without counting it as a drop.
  assign w_push = req_valid && !w_full && !w_dup && !flush;
  assign w_drop = req_valid && (w_full || w_dup) && !flush;

  always_comb begin
    w_state_nxt  = r_state;
    w_export_nxt = export_now;
    w_wait_nxt   = r_wait;
    w_load       = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sched_en && !w_empty && !flush) begin
          w_load       = 1'b1;
          w_export_nxt = 1'b1;
          w_wait_nxt   = '0;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flow_exported_ok) begin
          w_ack        = 1'b1;
          w_export_nxt = 1'b0;
          w_state_nxt  = S_GAP;
        end else if (r_wait == WW'(ACK_TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_export_nxt = 1'b0;
          w_state_nxt  = S_GAP;
        end else begin
          w_wait_nxt   = r_wait + 1'b1;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= req_index;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wait      <= '0;
      export_now  <= 1'b0;
      export_this <= '0;
      timeout_err <= 1'b0;
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      export_now <= w_export_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (flush) r_rd_ptr <= r_wr_ptr;
      else if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_load) export_this <= r_mem[r_rd_ptr[AW-1:0]];
      if (w_ack) issued_cnt <= issued_cnt + 32'd1;
      if (w_drop && (dropped_cnt != 16'hFFFF)) dropped_cnt <= dropped_cnt + 16'd1;
      if (w_timeout) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flow_export_scheduler.sv
// tb/tb_flow_export_scheduler.sv - directed scoreboard bench for flow_export_scheduler
module tb_flow_export_scheduler;
  localparam int IDX_W = 12;
`ifdef SCHED_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic             sched_en = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic [IDX_W-1:0] req_index = '0;
  logic             flow_exported_ok = 1'b0;
  logic             err_clr = 1'b0;
  logic             req_ready, export_now, busy, timeout_err;
  logic [IDX_W-1:0] export_this;
  logic [31:0]      issued_cnt;
  logic [15:0]      dropped_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_rise = 0;
  int exp_issued = 0;
  int exp_dropped = 0;
  logic [IDX_W-1:0] sb [$];
  logic             prev_now = 1'b0;
  logic [IDX_W-1:0] held = '0;

  flow_export_scheduler dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .sched_en(sched_en), .flush(flush),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .export_now(export_now), .export_this(export_this),
    .flow_exported_ok(flow_exported_ok), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each export_now rising edge consumes the oldest expected index.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_now = 1'b0;
    end else begin
      if (export_now && !prev_now) begin
        n_rise++;
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else chk("export_this_order", 32'(export_this), 32'(sb.pop_front()));
        held = export_this;
      end else if (export_now && prev_now) begin
        chk("export_this_stable", 32'(export_this), 32'(held));
      end
      prev_now = export_now;
    end
  end

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input bit expect_q);
    tick();
    req_valid = 1'b1;
    req_index = idx;
    if (expect_q) sb.push_back(idx);
  endtask

  task automatic wait_now(input int budget);
    int k = 0;
    while (export_now !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("wait_export_now", 32'(export_now), 32'd1);
  endtask

  task automatic ack_now();
    flow_exported_ok = 1'b1;
    tick();
    flow_exported_ok = 1'b0;
    exp_issued++;
  endtask

  initial begin
    int hi;
    int base;
    int pushed;
    logic last_now;

    // reset state
    tick();
    tick();
    chk("rst_export_now", 32'(export_now), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    ARESETN = 1'b1;
    tick();
    chk("rst_issued", issued_cnt, 32'd0);
    chk("rst_dropped", 32'(dropped_cnt), 32'd0);
    chk("rst_export_this", 32'(export_this), 32'd0);

    // T1 single request, ack two cycles in
    sched_en = 1'b1;
    push(12'h0A5, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("t1_lat_n1", 32'(export_now), 32'd0);
    chk("t1_busy_q", 32'(busy), 32'd1);
    tick();
    chk("t1_lat_n2", 32'(export_now), 32'd1);
    tick();
    tick();
    chk("t1_this", 32'(export_this), 32'h0A5);
    ack_now();
    chk("t1_now_drop", 32'(export_now), 32'd0);
    chk("t1_issued", issued_cnt, 32'(exp_issued));
    chk("t1_busy_gap", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_idle", 32'(busy), 32'd0);
    flow_exported_ok = 1'b1;
    tick();
    flow_exported_ok = 1'b0;
    tick();
    chk("stray_ack_ignored", issued_cnt, 32'(exp_issued));

    // T2 overflow
    sched_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 16) chk("t2_ready_full", 32'(req_ready), 32'd0);
      req_valid = 1'b1;
      req_index = IDX_W'(i);
      if (i < 16) sb.push_back(IDX_W'(i));
    end
    tick();
    req_valid = 1'b0;
    exp_dropped++;
    chk("t2_dropped", 32'(dropped_cnt), 32'(exp_dropped));
    chk("t2_ready_still_full", 32'(req_ready), 32'd0);
    chk("t2_no_issue_disabled", 32'(export_now), 32'd0);
    sched_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_now(10);
      ack_now();
    end
    chk("t2_issued", issued_cnt, 32'(exp_issued));
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);

    // T3 ack timeout
    push(12'h123, 1'b1);
    push(12'h456, 1'b1);
    tick();
    req_valid = 1'b0;
    wait_now(10);
    hi = 0;
    while (export_now === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    chk("t3_high_cycles", 32'(hi), 32'd64);
    chk("t3_timeout_err", 32'(timeout_err), 32'd1);
    chk("t3_issued_unchanged", issued_cnt, 32'(exp_issued));
    wait_now(10);
    ack_now();
    chk("t3_issued_next", issued_cnt, 32'(exp_issued));
    chk("t3_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(timeout_err), 32'd0);

    // T4 flush with one request in flight
    for (int i = 0; i < 5; i++) push(IDX_W'(12'h010 + i), 1'b1);
    tick();
    req_valid = 1'b0;
    wait_now(10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    base = n_rise;
    chk("t4_inflight_held", 32'(export_now), 32'd1);
    chk("t4_inflight_idx", 32'(export_this), 32'h010);
    ack_now();
    repeat (6) tick();
    chk("t4_busy_after_flush", 32'(busy), 32'd0);
    chk("t4_no_more_issues", 32'(n_rise), 32'(base));
    chk("t4_issued", issued_cnt, 32'(exp_issued));

    // T4 reset mid-handshake
    push(12'h020, 1'b1);
    push(12'h021, 1'b1);
    tick();
    req_valid = 1'b0;
    wait_now(10);
    ARESETN = 1'b0;
    #1;
    chk("t4_async_now", 32'(export_now), 32'd0);
    tick();
    sb.delete();
    exp_issued = 0;
    exp_dropped = 0;
    chk("t4_rst_this", 32'(export_this), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd1);
    chk("t4_rst_issued", issued_cnt, 32'd0);
    chk("t4_rst_dropped", 32'(dropped_cnt), 32'd0);
    chk("t4_rst_err", 32'(timeout_err), 32'd0);
    ARESETN = 1'b1;
    tick();

    // T5 repeated indices
    sched_en = 1'b0;
    push(12'h007, 1'b1);
    push(12'h007, !DEDUP);
    push(12'h008, 1'b1);
    push(12'h007, 1'b1);
    tick();
    req_valid = 1'b0;
    if (DEDUP) exp_dropped++;
    chk("t5_dropped", 32'(dropped_cnt), 32'(exp_dropped));
    sched_en = 1'b1;
    base = sb.size();
    for (int i = 0; i < base; i++) begin
      wait_now(10);
      ack_now();
    end
    chk("t5_issued", issued_cnt, 32'(exp_issued));
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);

    // T6 pointer wrap with push and pop on the same edge
    repeat (3) tick();
    sched_en = 1'b0;
    pushed = 0;
    for (int i = 0; i < 8; i++) begin
      push(IDX_W'(12'h300 + pushed), 1'b1);
      pushed++;
    end
    tick();
    req_valid = 1'b0;
    sched_en = 1'b1;
    base = n_rise;
    last_now = 1'b0;
    for (int c = 0; c < 400 && (n_rise - base) < 40; c++) begin
      tick();
      flow_exported_ok = export_now;
      if (export_now) exp_issued++;
      req_valid = 1'b0;
      if (!export_now && !last_now && pushed < 40) begin
        req_valid = 1'b1;
        req_index = IDX_W'(12'h300 + pushed);
        sb.push_back(req_index);
        pushed++;
      end
      last_now = export_now;
    end
    tick();
    flow_exported_ok = 1'b0;
    req_valid = 1'b0;
    chk("t6_rises", 32'(n_rise - base), 32'd40);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);
    chk("t6_issued", issued_cnt, 32'(exp_issued));
    chk("t6_no_drop", 32'(dropped_cnt), 32'(exp_dropped));
    repeat (3) tick();
    chk("t6_busy_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
